// File: rtl/pc_fetch_unit.sv
// Program counter and fetch sequencer feeding a registered, byte-addressed instruction memory.
// Tracks the PC of the word on the memory output and latches a sticky fault on a bad fetch address.
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] IMEM_LIMIT = 32'd496
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [25:0] jump_index,
    output logic [31:0] fetch_addr,
    output logic [31:0] if_pc,
    output logic [31:0] if_pc_plus4,
    output logic        if_valid,
    output logic        fetch_fault
);

    logic [31:0] pc;
    logic [31:0] jump_target;
    logic        hold;
    logic        bad_addr;

    assign jump_target = {if_pc_plus4[31:28], jump_index, 2'b00};

    // Once faulted the address stays parked on pc and every request is ignored.
    always_comb begin
        fetch_addr = pc;
        if (fetch_fault)
            fetch_addr = pc;
        else if (branch_taken)
            fetch_addr = branch_target;
        else if (jump)
            fetch_addr = jump_target;
        else if (stall && if_valid)
            fetch_addr = if_pc;
    end

    // A redirect overrides stall, so only a plain stall freezes the registers.
    assign hold     = stall & ~branch_taken & ~jump;
    assign bad_addr = (fetch_addr[1:0] != 2'b00) || (fetch_addr > IMEM_LIMIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc          <= RESET_PC;
            if_pc       <= 32'h0;
            if_pc_plus4 <= 32'h0;
            if_valid    <= 1'b0;
            fetch_fault <= 1'b0;
        end else if (!fetch_fault && !hold) begin
            if (bad_addr) begin
                fetch_fault <= 1'b1;
                if_valid    <= 1'b0;
            end else begin
                if_pc       <= fetch_addr;
                if_pc_plus4 <= fetch_addr + 32'd4;
                if_valid    <= 1'b1;
                pc          <= fetch_addr + 32'd4;
            end
        end
    end

endmodule
